// File: rtl/memory_mb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_mb_pkg
// Description : Default parameters and address-width helpers shared by the
//               multi-bank crossbar memory, its interface and the benches.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_mb_pkg;

  localparam int c_data_bit_width   = 32;
  localparam int c_num_banks        = 4;
  localparam int c_num_bank_entries = 64;
  localparam int c_num_ports        = 4;

  // Total word-address width covering every entry of every bank.
  function automatic int calc_addr_bit_width(input int nb, input int ne);
    return $clog2(nb * ne);
  endfunction

  // Low-order address bits used to pick the bank (interleaved mapping).
  function automatic int calc_bank_sel_width(input int nb);
    return $clog2(nb);
  endfunction

endpackage : memory_mb_pkg
`default_nettype wire

// File: rtl/memory_mb_xbar_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_mb_xbar_if
// Description : Request/response bundle between the requesters (master) and
//               the multi-bank crossbar memory (slave). Per-port fields are
//               packed vectors indexed by port number.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_mb_xbar_if
  import memory_mb_pkg::*;
#(
  parameter int data_bit_width   = c_data_bit_width,
  parameter int num_banks        = c_num_banks,
  parameter int num_bank_entries = c_num_bank_entries,
  parameter int num_ports        = c_num_ports
) ();

  localparam int addr_bit_width = calc_addr_bit_width(num_banks, num_bank_entries);

  logic [num_ports-1:0]                     req_valid;
  logic [num_ports-1:0]                     req_ready;
  logic [num_ports-1:0]                     req_we;
  logic [num_ports-1:0][addr_bit_width-1:0] req_addr;
  logic [num_ports-1:0][data_bit_width-1:0] req_wdata;
  logic [num_ports-1:0]                     rsp_valid;
  logic [num_ports-1:0][data_bit_width-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface : memory_mb_xbar_if
`default_nettype wire

// File: rtl/mb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mb_rr_arbiter
// Description : Round-robin arbiter with a one-hot grant. The search starts
//               at the pointer; after a grant to g the pointer moves to g+1
//               (wrapping), and it stays put when nothing is granted.
//               No grant is issued while rst is high.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_rr_arbiter #(
  parameter int num_req = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [num_req-1:0] req,
  output logic      [num_req-1:0] gnt
);

  localparam int c_ptr_w = (num_req > 1) ? $clog2(num_req) : 1;

  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] w_ptr_next;
  logic [num_req-1:0] w_mask;
  logic [num_req-1:0] w_hi;
  logic [num_req-1:0] w_sel;

  // Pick the lowest requester at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    gnt        = '0;
    w_ptr_next = r_ptr;
    w_mask     = '0;
    for (int j = 0; j < num_req; j++) begin
      w_mask[j] = (j >= int'(r_ptr));
    end
    w_hi  = req & w_mask;
    w_sel = (|w_hi) ? w_hi : req;
    for (int j = num_req - 1; j >= 0; j--) begin
      if (w_sel[j]) begin
        gnt        = '0;
        gnt[j]     = 1'b1;
        w_ptr_next = (j == num_req - 1) ? '0 : c_ptr_w'(j + 1);
      end
    end
    if (rst) begin
      gnt = '0;
    end
  end

  // Advance the pointer only when a grant was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|req) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule : mb_rr_arbiter
`default_nettype wire

// File: rtl/memory_dp.sv
`default_nettype none
// ============================================================================
// Module      : memory_dp
// Description : Simple dual-port RAM, one write and one registered read per
//               cycle. A same-cycle read and write of one entry returns the
//               old word. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_dp #(
  parameter int data_bit_width = 32,
  parameter int num_entries    = 64,
  localparam int c_entry_w     = (num_entries > 1) ? $clog2(num_entries) : 1
) (
  input  wire logic                      wr_clk,
  input  wire logic                      wr_en,
  input  wire logic [c_entry_w-1:0]      wr_addr,
  input  wire logic [data_bit_width-1:0] wr_data,
  input  wire logic                      rd_clk,
  input  wire logic                      rd_en,
  input  wire logic [c_entry_w-1:0]      rd_addr,
  output logic      [data_bit_width-1:0] rd_data
);

  logic [data_bit_width-1:0] r_mem [num_entries];

  // Write port.
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read port; registered so the pre-write contents are returned on a collision.
  always_ff @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule : memory_dp
`default_nettype wire

// File: rtl/memory_mb_xbar.sv
`default_nettype none
// ============================================================================
// Module      : memory_mb_xbar
// Description : Shared multi-bank scratchpad. Any port reaches any address;
//               banks are low-order interleaved. Each bank has independent
//               round-robin read and write arbiters, so per bank one read and
//               one write complete each cycle. Reads return one cycle later
//               on the requesting port.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_mb_xbar
  import memory_mb_pkg::*;
#(
  parameter int data_bit_width   = c_data_bit_width,
  parameter int num_banks        = c_num_banks,
  parameter int num_bank_entries = c_num_bank_entries,
  parameter int num_ports        = c_num_ports
) (
  input  wire logic        clk,
  input  wire logic        rst,
  memory_mb_xbar_if.slave  bus
);

  localparam int addr_bit_width = calc_addr_bit_width(num_banks, num_bank_entries);
  localparam int bank_sel_width = calc_bank_sel_width(num_banks);
  localparam int c_entry_w      = addr_bit_width - bank_sel_width;

  logic [bank_sel_width-1:0] w_bank  [num_ports];
  logic [c_entry_w-1:0]      w_entry [num_ports];

  logic [num_banks-1:0][num_ports-1:0] w_wr_req;
  logic [num_banks-1:0][num_ports-1:0] w_rd_req;
  logic [num_banks-1:0][num_ports-1:0] w_wr_gnt;
  logic [num_banks-1:0][num_ports-1:0] w_rd_gnt;
  logic [num_banks-1:0][num_ports-1:0] r_rd_tag;

  logic [data_bit_width-1:0] w_rd_data [num_banks];

  logic [num_ports-1:0]                     w_ready;
  logic [num_ports-1:0]                     w_rsp_valid;
  logic [num_ports-1:0][data_bit_width-1:0] w_rsp_data;
  logic [num_ports-1:0][data_bit_width-1:0] r_rsp_hold;

  // Split every port address into bank select and in-bank entry.
  always_comb begin
    for (int p = 0; p < num_ports; p++) begin
      w_bank[p]  = bus.req_addr[p][bank_sel_width-1:0];
      w_entry[p] = bus.req_addr[p][addr_bit_width-1:bank_sel_width];
    end
  end

  // Route each valid request to the read or write arbiter of its bank.
  always_comb begin
    w_wr_req = '0;
    w_rd_req = '0;
    for (int b = 0; b < num_banks; b++) begin
      for (int p = 0; p < num_ports; p++) begin
        if (bus.req_valid[p] && (w_bank[p] == bank_sel_width'(b))) begin
          w_wr_req[b][p] = bus.req_we[p];
          w_rd_req[b][p] = ~bus.req_we[p];
        end
      end
    end
  end

  generate
    for (genvar b = 0; b < num_banks; b++) begin : g_bank
      logic                      w_wr_en;
      logic                      w_rd_en;
      logic [c_entry_w-1:0]      w_wr_entry;
      logic [c_entry_w-1:0]      w_rd_entry;
      logic [data_bit_width-1:0] w_wr_data;

      mb_rr_arbiter #(.num_req(num_ports)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (w_wr_req[b]),
        .gnt (w_wr_gnt[b])
      );

      mb_rr_arbiter #(.num_req(num_ports)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (w_rd_req[b]),
        .gnt (w_rd_gnt[b])
      );

      // One-hot grant muxes the winning port's entry and data onto the bank.
      always_comb begin
        w_wr_en    = |w_wr_gnt[b];
        w_rd_en    = |w_rd_gnt[b];
        w_wr_entry = '0;
        w_rd_entry = '0;
        w_wr_data  = '0;
        for (int p = 0; p < num_ports; p++) begin
          if (w_wr_gnt[b][p]) begin
            w_wr_entry = w_wr_entry | w_entry[p];
            w_wr_data  = w_wr_data | bus.req_wdata[p];
          end
          if (w_rd_gnt[b][p]) begin
            w_rd_entry = w_rd_entry | w_entry[p];
          end
        end
      end

      memory_dp #(
        .data_bit_width (data_bit_width),
        .num_entries    (num_bank_entries)
      ) u_bank (
        .wr_clk  (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_entry),
        .wr_data (w_wr_data),
        .rd_clk  (clk),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_entry),
        .rd_data (w_rd_data[b])
      );
    end
  endgenerate

  // A port is ready when any bank arbiter granted it.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < num_banks; b++) begin
      w_ready = w_ready | w_wr_gnt[b] | w_rd_gnt[b];
    end
  end

  // Remember which port each bank read belongs to for next-cycle steering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_tag <= '0;
    end else begin
      r_rd_tag <= w_rd_gnt;
    end
  end

  // Steer bank read data to the tagged port; idle ports show their last word.
  always_comb begin
    w_rsp_valid = '0;
    w_rsp_data  = r_rsp_hold;
    for (int b = 0; b < num_banks; b++) begin
      for (int p = 0; p < num_ports; p++) begin
        if (r_rd_tag[b][p] && !rst) begin
          w_rsp_valid[p] = 1'b1;
          w_rsp_data[p]  = w_rd_data[b];
        end
      end
    end
  end

  // Keep the visible response word so it holds while no response is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_hold <= '0;
    end else begin
      r_rsp_hold <= w_rsp_data;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_data;

endmodule : memory_mb_xbar
`default_nettype wire

// File: doc/memory_mb_xbar.md
# memory_mb_xbar

Multi-port, multi-bank single-clock memory with per-bank arbitration. `num_ports` independent requesters share `num_banks` dual-port banks addressed by low-order interleaving. Each bank runs one read and one write per cycle, and conflicting requesters are served round-robin under a valid/ready handshake. This is the shared-scratchpad successor to the fixed per-bank-wired multi-bank memory. Requesters no longer own a bank; any port reaches any address.

## Interface
Parameters:
- `data_bit_width`, 32, word width
- `num_banks`, 4, bank count; power of two, ≥ 2
- `num_bank_entries`, 64, words per bank; power of two
- `num_ports`, 4, requester count, ≥ 1
- `addr_bit_width`, localparam, `$clog2(num_banks*num_bank_entries)`
- `bank_sel_width`, localparam, `$clog2(num_banks)`

Ports (per-port signals are unpacked arrays `[num_ports]` or packed vectors `[num_ports-1:0]`):
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  num_ports  request present
- `req_ready`  out  num_ports  request accepted this cycle
- `req_we`  in  num_ports  1 = write, 0 = read
- `req_addr`  in  addr_bit_width ×num_ports  word address
- `req_wdata`  in  data_bit_width ×num_ports  write data
- `rsp_valid`  out  num_ports  read data valid
- `rsp_rdata`  out  data_bit_width ×num_ports  read data

## Operation
- Address decode:
  - bank = `req_addr[bank_sel_width-1:0]`
  - entry = `req_addr[addr_bit_width-1:bank_sel_width]`
- Each bank has two independent round-robin arbiters:
  - write arbiter: candidates are ports with `req_valid & req_we` targeting that bank
  - read arbiter: candidates are ports with `req_valid & ~req_we` targeting that bank
- A port targets exactly one bank and one type per cycle, so it receives at most one grant. `req_ready[p]` = OR of its grants.
- `req_ready` is combinational from `req_valid`, `req_we`, `req_addr` and the arbiter state. It depends on nothing else. It is asserted even when no request is present only if computed as 0; that is, `req_ready[p]` implies `req_valid[p]`.
- Transfer = `req_valid & req_ready` on a rising edge.
- Requesters hold request fields stable while valid and not ready. A requester may drop or change an unaccepted request, and the block tolerates it.
- Round-robin pointer per arbiter:
  - After a grant to port g, the pointer becomes `(g+1) mod num_ports`.
  - Search starts at the pointer.
  - The pointer is unchanged when there is no grant.
- Accepted write: the bank entry is updated at that edge.
- Accepted read: the bank is read at that edge. The data returns on the same port as `rsp_valid`/`rsp_rdata` in the next cycle.
- Read and write to the same bank and entry in the same cycle: the read returns the old data. A write followed by a read in a later cycle returns the new data.
- Two writes to the same address in different cycles: the last one wins.
- Memory contents are not reset.

## Timing
- Read latency is exactly 1 cycle from accept to `rsp_valid` for one cycle. There is no backpressure on responses.
- Responses per port are in order, since latency is fixed.
- Throughput is 1 request per port per cycle when there are no conflicts.
- Per bank per cycle: at most 1 read and 1 write.
- Worst-case wait for a continuously valid request is `num_ports-1` cycles.
- While `rst` = 1:
  - `req_ready` = 0
  - no bank access
- Values on the cycle after `rst` is sampled high:
  - `rsp_valid` = 0
  - `rsp_rdata` = 0
  - all arbiter pointers = 0
- Reset during an outstanding read suppresses that response.
- `rsp_rdata` holds its last value when `rsp_valid` = 0.

## Structure
- `memory_mb_pkg` holds the parameter defaults and the `addr_bit_width`/`bank_sel_width` helper functions.
- Sub-module `mb_rr_arbiter`, parameter `num_req`. It has:
  - inputs `clk`, `rst`, `req[num_req]`
  - outputs one-hot `gnt`
  - an internal pointer
- `memory_mb_xbar` instantiates `2×num_banks` arbiters and `num_banks` `memory_dp` instances:
  - `wr_clk` = `rd_clk` = `clk`
  - `memory_dp` has read latency 1 and returns old data on a same-cycle read/write
- Per-bank read grants are registered as one-hot port tags. These steer `rd_data` to `rsp_rdata` in the following cycle.

## Test plan
- Defaults. Port 0 writes `0xDEADBEEF` to address 5, then reads address 5 → `req_ready` 1 both cycles; `rsp_valid[0]` 1 cycle after the read with `0xDEADBEEF`.
- Conflict:
  - stimulus: ports 0–3 all read bank 1 (addresses 1, 5, 9, 13) continuously
  - required: grants in order 0, 1, 2, 3, one per cycle
  - required: each `rsp_valid` follows its grant by 1 cycle with the correct data
- No conflict: ports 0–3 read addresses 0, 1, 2, 3 in the same cycle → all `req_ready` = 1 and all four `rsp_valid` the next cycle.
- Same cycle:
  - stimulus: port 0 writes `0x11` to address 8 (old data `0x22`) while port 1 reads address 8
  - required: both accepted; port 1 gets `0x22`; a later read returns `0x11`
- Reset:
  - stimulus: assert `rst` in the cycle after a read accept
  - required: `rsp_valid` = 0, `req_ready` = 0 during reset
  - required: after release, a 4-way conflict is granted starting at port 0
- Random: random mixed traffic against a reference model → no lost or duplicated responses; data matches the model; no port starves beyond 3 cycles.
